// File: rtl/vga_wr_pkg.sv
// Shared types and constants for the CPU-to-video write bridge.
// The VRAM window is the top 8 KiB of the CPU address space.
package vga_wr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } wr_state_t;

   localparam logic [2:0]  VRAM_REGION = 3'b111;
   localparam logic [15:0] RESET_ADDR  = 16'hE000;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_entry_t;

   function automatic logic in_vram(input logic [15:0] addr);
      return addr[15:13] == VRAM_REGION;
   endfunction

endpackage

// File: rtl/vga_wr_fifo.sv
// Write buffer between the CPU port and the video bus sequencer.
// With VGA_WR_COALESCE_EN defined, a write to the newest entry's address merges into it.
module vga_wr_fifo
   import vga_wr_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      wr_en,
   input  wr_entry_t wr_entry,
   input  logic      pop,
   output wr_entry_t head,
   output logic      full,
   output logic      empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wr_entry_t     mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          alloc;
   logic          do_pop;

   assign full   = count == CW'(DEPTH);
   assign empty  = count == '0;
   assign do_pop = pop && !empty;
   assign head   = mem[rd_ptr];

`ifdef VGA_WR_COALESCE_EN
   logic [PW-1:0] newest_ptr;
   logic          merge;

   // The only entry leaving this cycle is no longer a merge target.
   assign newest_ptr = wr_ptr - PW'(1);
   assign merge      = wr_en && !empty
                       && (mem[newest_ptr].addr == wr_entry.addr)
                       && !((count == CW'(1)) && do_pop);
   assign alloc      = wr_en && !merge && !full;
`else
   assign alloc      = wr_en && !full;
`endif

   always_ff @(posedge clk) begin
      if (alloc) begin
         mem[wr_ptr] <= wr_entry;
      end
`ifdef VGA_WR_COALESCE_EN
      else if (merge) begin
         mem[newest_ptr].data <= wr_entry.data;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (alloc) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({alloc, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vga_wr_bridge.sv
// Buffers CPU writes into the VRAM window and replays them on the video bus.
// Optional write merging is enabled with VGA_WR_COALESCE_EN (see vga_wr_fifo).
//
// state     | meaning
// ST_IDLE   | waiting for a buffered write; pops it into the a/d register
// ST_SETUP  | a/d driven, n_we high, waiting for n_rdy low
// ST_STROBE | n_we low for one cycle; n_rdy high here means retry from SETUP
// ST_HOLD   | n_we high, a/d held one more cycle before the next pop
module vga_wr_bridge
   import vga_wr_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_d,
   input  logic        cpu_wr,
   output logic        cpu_stall,
   output logic [15:0] a,
   output logic [7:0]  d,
   output logic        n_we,
   output logic        n_oe,
   input  logic        n_rdy,
   output logic        idle
);

   wr_state_t state;
   wr_entry_t head;
   wr_entry_t wr_entry;
   logic      fifo_full;
   logic      fifo_empty;
   logic      wr_en;
   logic      pop;

   assign wr_entry = '{addr: cpu_a, data: cpu_d};
   assign wr_en    = cpu_wr && in_vram(cpu_a);
   assign pop      = (state == ST_IDLE) && !fifo_empty;

   vga_wr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_entry (wr_entry),
      .pop      (pop),
      .head     (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign cpu_stall = fifo_full;
   assign n_oe      = 1'b1;
   assign idle      = (state == ST_IDLE) && fifo_empty;

   // a/d load only on the pop, so they stay stable across a retried strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         a     <= RESET_ADDR;
         d     <= '0;
         n_we  <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               n_we <= 1'b1;
               if (!fifo_empty) begin
                  a     <= head.addr;
                  d     <= head.data;
                  state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (!n_rdy) begin
                  n_we  <= 1'b0;
                  state <= ST_STROBE;
               end
            end
            ST_STROBE: begin
               n_we  <= 1'b1;
               state <= n_rdy ? ST_SETUP : ST_HOLD;
            end
            ST_HOLD: begin
               n_we  <= 1'b1;
               state <= ST_IDLE;
            end
            default: begin
               n_we  <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_wr_bridge.sv
// Self-checking bench for vga_wr_bridge: directed bus-timing cases plus randomized
// bursts checked against a queue model of the write buffer (honours VGA_WR_COALESCE_EN).
module tb_vga_wr_bridge;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_a;
   logic [7:0]  cpu_d;
   logic        cpu_wr;
   logic        cpu_stall;
   logic [15:0] a;
   logic [7:0]  d;
   logic        n_we;
   logic        n_oe;
   logic        n_rdy;
   logic        idle;

   always #5 clk = ~clk;

   vga_wr_bridge #(.FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_a     (cpu_a),
      .cpu_d     (cpu_d),
      .cpu_wr    (cpu_wr),
      .cpu_stall (cpu_stall),
      .a         (a),
      .d         (d),
      .n_we      (n_we),
      .n_oe      (n_oe),
      .n_rdy     (n_rdy),
      .idle      (idle)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int pulses   = 0;
   int last_strobe_cyc = -1;

   logic [23:0] bus_q[$];
   logic [23:0] exp_q[$];
   logic [23:0] mq[$];
   logic [15:0] ba[$];
   logic [7:0]  bd[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor: a strobe completes when n_rdy is low during the n_we-low cycle.
   always @(negedge clk) begin
      if (rst === 1'b0 && n_we === 1'b0) begin
         pulses = pulses + 1;
         last_strobe_cyc = cyc;
         if (n_rdy === 1'b0) bus_q.push_back({a, d});
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Buffer model: region filter, optional merge into newest entry, capacity limit.
   function automatic void model_push(input logic [15:0] addr, input logic [7:0] data);
      if (addr[15:13] != 3'b111) return;
`ifdef VGA_WR_COALESCE_EN
      if (mq.size() > 0 && mq[mq.size()-1][23:8] == addr) begin
         mq[mq.size()-1] = {addr, data};
         return;
      end
`endif
      if (mq.size() < DEPTH) mq.push_back({addr, data});
   endfunction

   task automatic drain(input int n, input string tag);
      int k = 0;
      while ((bus_q.size() < n || idle !== 1'b1) && k < 300) begin
         tick();
         k++;
      end
      chk({tag, "_drained"}, 32'(k < 300), 32'd1);
   endtask

   task automatic cmp_bus(input string tag);
      chk({tag, "_nwrites"}, bus_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < bus_q.size(); i++)
         chk($sformatf("%s_w%0d", tag, i), bus_q[i], exp_q[i]);
      bus_q.delete();
      exp_q.delete();
   endtask

   // Park the sequencer in SETUP holding pre, then drive ba/bd back-to-back.
   task automatic blocked_burst(input string tag, input logic [23:0] pre);
      int base;
      n_rdy = 1'b1;
      bus_q.delete();
      exp_q.delete();
      mq.delete();
      cpu_a = pre[23:8]; cpu_d = pre[7:0]; cpu_wr = 1'b1;
      tick();
      cpu_wr = 1'b0;
      tick();
      tick();
      base = pulses;
      exp_q.push_back(pre);
      for (int i = 0; i < ba.size(); i++) begin
         cpu_a = ba[i]; cpu_d = bd[i]; cpu_wr = 1'b1;
         @(negedge clk);
         chk($sformatf("%s_stall%0d", tag, i), 32'(cpu_stall), 32'(mq.size() == DEPTH));
         model_push(ba[i], bd[i]);
         tick();
      end
      cpu_wr = 1'b0;
      @(negedge clk);
      chk({tag, "_stall_end"}, 32'(cpu_stall), 32'(mq.size() == DEPTH));
      chk({tag, "_held_a"}, a, pre[23:8]);
      chk({tag, "_no_strobe"}, pulses, base);
      foreach (mq[i]) exp_q.push_back(mq[i]);
      tick();
      n_rdy = 1'b0;
      drain(exp_q.size(), tag);
      cmp_bus(tag);
   endtask

   initial begin
      int base;
      int push_cyc;
      int seq;
      logic [23:0] pre;
      logic [15:0] addr;

      rst = 1'b1; cpu_a = '0; cpu_d = '0; cpu_wr = 1'b0; n_rdy = 1'b1;
      tick(); tick(); tick();
      @(negedge clk);
      chk("rst_a", a, 16'hE000);
      chk("rst_d", d, 8'h00);
      chk("rst_n_we", n_we, 1'b1);
      chk("rst_n_oe", n_oe, 1'b1);
      chk("rst_stall", cpu_stall, 1'b0);
      chk("rst_idle", idle, 1'b1);
      tick();
      rst = 1'b0;
      tick();

      // Single write with the bus always ready.
      n_rdy = 1'b0; base = pulses; bus_q.delete();
      cpu_a = 16'hE005; cpu_d = 8'h41; cpu_wr = 1'b1; push_cyc = cyc;
      tick();
      cpu_wr = 1'b0;
      tick(); tick(); tick();
      @(negedge clk);
      chk("single_hold_idle", idle, 1'b0);
      chk("single_hold_n_we", n_we, 1'b1);
      tick();
      @(negedge clk);
      chk("single_idle_back", idle, 1'b1);
      chk("single_pulses", pulses - base, 1);
      chk("single_latency", last_strobe_cyc, push_cyc + 3);
      exp_q.push_back({16'hE005, 8'h41});
      cmp_bus("single");

      // Bus busy for 20 cycles before accepting.
      n_rdy = 1'b1; base = pulses;
      cpu_a = 16'hF010; cpu_d = 8'h55; cpu_wr = 1'b1;
      tick();
      cpu_wr = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      @(negedge clk);
      chk("wait_no_strobe", pulses, base);
      chk("wait_a", a, 16'hF010);
      chk("wait_d", d, 8'h55);
      chk("wait_idle", idle, 1'b0);
      tick();
      n_rdy = 1'b0;
      drain(1, "wait");
      chk("wait_pulses", pulses - base, 1);
      exp_q.push_back({16'hF010, 8'h55});
      cmp_bus("wait");

      // n_rdy rises during the strobe: retry the same entry.
      n_rdy = 1'b1; base = pulses;
      cpu_a = 16'hE123; cpu_d = 8'h9A; cpu_wr = 1'b1;
      tick();
      cpu_wr = 1'b0;
      tick();
      n_rdy = 1'b0;
      tick();
      n_rdy = 1'b1;
      @(negedge clk);
      chk("retry_first_strobe", n_we, 1'b0);
      tick();
      n_rdy = 1'b0;
      @(negedge clk);
      chk("retry_back_setup", n_we, 1'b1);
      chk("retry_a_stable", a, 16'hE123);
      chk("retry_d_stable", d, 8'h9A);
      drain(1, "retry");
      chk("retry_pulses", pulses - base, 2);
      exp_q.push_back({16'hE123, 8'h9A});
      cmp_bus("retry");

      // Out-of-window write is ignored.
      n_rdy = 1'b0; base = pulses;
      cpu_a = 16'h1234; cpu_d = 8'h77; cpu_wr = 1'b1;
      tick();
      cpu_wr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("ignore_idle%0d", i), idle, 1'b1);
         tick();
      end
      chk("ignore_pulses", pulses, base);

      // Fill to capacity behind a held write; fifth burst write is dropped.
      ba.delete(); bd.delete();
      for (int i = 0; i < 5; i++) begin
         ba.push_back(16'hE301 + 16'(i));
         bd.push_back(8'h11 + 8'(i));
      end
      blocked_burst("full", {16'hE300, 8'h10});

      // Two writes to the same address while blocked.
      ba.delete(); bd.delete();
      ba.push_back(16'hF000); bd.push_back(8'h01);
      ba.push_back(16'hF000); bd.push_back(8'h02);
      blocked_burst("same_addr", {16'hE400, 8'hAA});

      // Randomized blocked bursts with mixed in/out-of-window and repeated addresses.
      for (int r = 0; r < 6; r++) begin
         ba.delete(); bd.delete();
         for (int i = 0; i < int'($urandom_range(1, 7)); i++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind < 2)
               addr = 16'($urandom_range(0, 16'hDFFF));
            else if (kind < 5 && ba.size() > 0)
               addr = ba[ba.size()-1];
            else
               addr = 16'hE000 | 16'($urandom_range(0, 16'h1FFF));
            ba.push_back(addr);
            bd.push_back(8'($urandom_range(0, 255)));
         end
         pre = {16'hE000 | 16'($urandom_range(0, 16'h1FFF)), 8'($urandom_range(0, 255))};
         blocked_burst($sformatf("rand%0d", r), pre);
      end

      // Random bus readiness with flow-controlled writes: order must be preserved.
      bus_q.delete(); exp_q.delete(); seq = 0;
      for (int i = 0; i < 300; i++) begin
         n_rdy = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 2) == 0 && cpu_stall === 1'b0) begin
            cpu_a = 16'hE000 + 16'(seq);
            cpu_d = 8'($urandom_range(0, 255));
            cpu_wr = 1'b1;
            exp_q.push_back({cpu_a, cpu_d});
            seq++;
         end else begin
            cpu_wr = 1'b0;
         end
         tick();
      end
      cpu_wr = 1'b0;
      n_rdy = 1'b0;
      drain(exp_q.size(), "flow");
      cmp_bus("flow");

      // Reset during a strobe with three writes still buffered.
      n_rdy = 1'b1;
      cpu_a = 16'hE500; cpu_d = 8'h50; cpu_wr = 1'b1;
      tick();
      cpu_wr = 1'b0;
      tick();
      for (int i = 1; i <= 3; i++) begin
         cpu_a = 16'hE500 + 16'(i); cpu_d = 8'h50 + 8'(i); cpu_wr = 1'b1;
         tick();
      end
      cpu_wr = 1'b0;
      base = pulses;
      bus_q.delete();
      n_rdy = 1'b0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_strobe_active", n_we, 1'b0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_strobe_n_we", n_we, 1'b1);
      chk("rst_strobe_idle", idle, 1'b1);
      chk("rst_strobe_stall", cpu_stall, 1'b0);
      chk("rst_strobe_a", a, 16'hE000);
      for (int i = 0; i < 15; i++) tick();
      chk("rst_strobe_no_writes", pulses, base);
      chk("rst_strobe_bus_empty", bus_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
